// File: rtl/rotary_pkg.sv
// rotary_pkg: shared FSM states, phase codes and acceleration constants for rotary_decoder_array.
package rotary_pkg;
    typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3} state_t;
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam int ACCEL_WINDOW = 50000;
    localparam int ACCEL_STEP = 4;
endpackage

// File: rtl/rotary_channel.sv
// rotary_channel: one encoder - synchroniser, debounce, detent FSM and signed position counter.
// ROTARY_ACCEL_EN adds an inter-step timer that enlarges fast same-direction steps.
module rotary_channel
    import rotary_pkg::*;
#(
    parameter int POS_WIDTH = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WRAP = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           pins,
    input  logic                 clear,
    output logic                 step_valid,
    output logic                 step_dir,
    output logic                 error,
    output logic [POS_WIDTH-1:0] position
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic signed [POS_WIDTH+3:0] PMAX = (POS_WIDTH+4)'((1 << (POS_WIDTH - 1)) - 1);
    localparam logic signed [POS_WIDTH+3:0] PMIN = ~PMAX;
    logic [1:0] s1, s2, ph, ph_q;
    logic [CNT_W-1:0] cnt [2];
    state_t state, nxt;
    logic stp, dir, jump;
    logic signed [POS_WIDTH+3:0] mag, sum;
    logic [POS_WIDTH-1:0] nxt_pos;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
        end
    // filtered bit follows the synced pin only after an unbroken run of DEBOUNCE_CYCLES
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            ph <= PH_00;
            cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++)
                if (s2[i] == ph[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    ph[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
        end
    always_comb begin
        nxt = state;
        stp = 1'b0;
        dir = 1'b0;
        jump = (ph ^ ph_q) == 2'b11;
        if (jump) nxt = (ph == PH_00) ? IDLE : state;
        else if (ph != ph_q)
            case (state)
                IDLE: nxt = (ph == PH_01) ? CW1 : (ph == PH_10) ? CCW1 : IDLE;
                CW1:  nxt = (ph == PH_11) ? CW2 : (ph == PH_00) ? IDLE : CW1;
                CW2:  nxt = (ph == PH_10) ? CW3 : (ph == PH_01) ? CW1 : CW2;
                CW3: begin
                    nxt = (ph == PH_00) ? IDLE : (ph == PH_11) ? CW2 : CW3;
                    stp = ph == PH_00;
                    dir = 1'b1;
                end
                CCW1: nxt = (ph == PH_11) ? CCW2 : (ph == PH_00) ? IDLE : CCW1;
                CCW2: nxt = (ph == PH_01) ? CCW3 : (ph == PH_10) ? CCW1 : CCW2;
                CCW3: begin
                    nxt = (ph == PH_00) ? IDLE : (ph == PH_11) ? CCW2 : CCW3;
                    stp = ph == PH_00;
                end
                default: nxt = IDLE;
            endcase
    end
`ifdef ROTARY_ACCEL_EN
    logic [15:0] timer;
    logic last_dir;
    // timer reads N at the edge N cycles after the previous step; all-ones means none yet
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            timer <= '1;
            last_dir <= 1'b0;
        end else if (stp) begin
            timer <= 16'd1;
            last_dir <= dir;
        end else if (timer != '1) timer <= timer + 16'd1;
    assign mag = (POS_WIDTH+4)'((timer < 16'(ACCEL_WINDOW) && last_dir == dir) ? ACCEL_STEP : 1);
`else
    assign mag = (POS_WIDTH+4)'(1);
`endif
    assign sum = $signed({{4{position[POS_WIDTH-1]}}, position}) + (dir ? mag : -mag);
    assign nxt_pos = (WRAP != 0) ? sum[POS_WIDTH-1:0] :
                     (sum > PMAX) ? PMAX[POS_WIDTH-1:0] :
                     (sum < PMIN) ? PMIN[POS_WIDTH-1:0] : sum[POS_WIDTH-1:0];
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            ph_q <= PH_00;
            step_valid <= 1'b0;
            step_dir <= 1'b0;
            error <= 1'b0;
            position <= '0;
        end else begin
            state <= nxt;
            ph_q <= ph;
            step_valid <= stp;
            error <= jump;
            if (stp) step_dir <= dir;
            if (clear) position <= '0;
            else if (stp) position <= nxt_pos;
        end
endmodule

// File: rtl/rotary_decoder_array.sv
// rotary_decoder_array: CHANNELS independent quadrature decoders plus a registered LED view of one channel.
// Optional ROTARY_ACCEL_EN enables step acceleration inside each channel.
module rotary_decoder_array
    import rotary_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int POS_WIDTH = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WRAP = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [2*CHANNELS-1:0]         rotary,
    input  logic [CHANNELS-1:0]           clear,
    input  logic [$clog2(CHANNELS):0]     sel,
    output logic [CHANNELS-1:0]           step_valid,
    output logic [CHANNELS-1:0]           step_dir,
    output logic [CHANNELS-1:0]           error,
    output logic [CHANNELS*POS_WIDTH-1:0] position,
    output logic [7:0]                    leds
);
    localparam int NV = 2 ** ($clog2(CHANNELS) + 1);
    logic [7:0] view [NV];
    // every sel code has a view entry; codes past CHANNELS read as zero
    for (genvar c = 0; c < NV; c++) begin : g_ch
        if (c < CHANNELS) begin : g_on
            rotary_channel #(
                .POS_WIDTH(POS_WIDTH),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .WRAP(WRAP)
            ) u_ch (
                .clock(clock),
                .reset(reset),
                .pins(rotary[2*c +: 2]),
                .clear(clear[c]),
                .step_valid(step_valid[c]),
                .step_dir(step_dir[c]),
                .error(error[c]),
                .position(position[c*POS_WIDTH +: POS_WIDTH])
            );
            assign view[c] = 8'(position[c*POS_WIDTH +: POS_WIDTH]);
        end else begin : g_off
            assign view[c] = '0;
        end
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) leds <= '0;
        else leds <= view[sel];
endmodule

// File: tb/tb_rotary_decoder_array.sv
// tb_rotary_decoder_array: scoreboard bench for a 3-channel wrapping array and a 1-channel saturating array.
module tb_rotary_decoder_array;
    typedef struct {
        int         ch;
        logic       dir;
        logic [7:0] pos;
        logic [7:0] spos;
    } exp_t;
    logic clock = 0;
    logic reset = 0;
    logic [5:0] rotary = '0;
    logic [2:0] clear = '0;
    logic [2:0] sel = '0;
    logic [2:0] step_valid, step_dir, error;
    logic [23:0] position;
    logic [7:0] leds;
    logic s_valid, s_dir, s_error;
    logic [7:0] s_position, s_leds;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_cnt[3] = '{0, 0, 0};
    int err_s = 0;
    exp_t q[$];
    exp_t r;
    logic [7:0] exp_pos[3] = '{8'd0, 8'd0, 8'd0};
    logic [7:0] exp_s = 8'd0;
`ifdef ROTARY_ACCEL_EN
    int last_cyc[3];
    logic last_dir[3];
    bit have[3] = '{0, 0, 0};
`endif

    rotary_decoder_array #(.CHANNELS(3), .POS_WIDTH(8), .DEBOUNCE_CYCLES(4), .WRAP(1)) dut (
        .clock(clock), .reset(reset), .rotary(rotary), .clear(clear), .sel(sel),
        .step_valid(step_valid), .step_dir(step_dir), .error(error),
        .position(position), .leds(leds)
    );
    rotary_decoder_array #(.CHANNELS(1), .POS_WIDTH(8), .DEBOUNCE_CYCLES(4), .WRAP(0)) dut_s (
        .clock(clock), .reset(reset), .rotary(rotary[1:0]), .clear(clear[0:0]), .sel(1'b0),
        .step_valid(s_valid), .step_dir(s_dir), .error(s_error),
        .position(s_position), .leds(s_leds)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_step(input int c, input logic d, input bit clr);
        int m, s;
        m = 1;
`ifdef ROTARY_ACCEL_EN
        if (have[c] && last_dir[c] == d && cyc - last_cyc[c] < 50000) m = 4;
        have[c] = 1;
        last_dir[c] = d;
        last_cyc[c] = cyc;
`endif
        exp_pos[c] = clr ? 8'd0 : exp_pos[c] + (d ? 8'(m) : -8'(m));
        if (c == 0) begin
            s = $signed(exp_s) + (d ? m : -m);
            s = (s > 127) ? 127 : (s < -128) ? -128 : s;
            exp_s = clr ? 8'd0 : 8'(s);
        end
        q.push_back('{c, d, exp_pos[c], exp_s});
    endtask

    // one full detent per selected channel; cwm channels clockwise, ccwm counter-clockwise
    task automatic turn(input logic [2:0] cwm, input logic [2:0] ccwm, input bit clr);
        logic [1:0] cs[4];
        logic [1:0] cc[4];
        int lat;
        cs = '{2'b01, 2'b11, 2'b10, 2'b00};
        cc = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++)
                if (cwm[c]) rotary[2*c +: 2] = cs[i];
                else if (ccwm[c]) rotary[2*c +: 2] = cc[i];
            wait_cyc(10);
        end
        for (int c = 0; c < 3; c++)
            if (cwm[c] | ccwm[c]) model_step(c, cwm[c], clr);
        for (int c = 0; c < 3; c++)
            if (cwm[c] | ccwm[c]) rotary[2*c +: 2] = 2'b00;
        lat = 0;
        while (lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
            if (clr && lat == 6) clear = cwm | ccwm;
            if (|(step_valid & (cwm | ccwm))) break;
        end
        clear = '0;
        check("step_latency", lat, 7);
        wait_cyc(10);
    endtask

    initial forever begin
        @(negedge clock);
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                if (error[c]) err_cnt[c]++;
                if (step_valid[c]) begin
                    check("sb_pending", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        r = q.pop_front();
                        check("sb_chan", c, r.ch);
                        check("sb_dir", step_dir[c], r.dir);
                        check("sb_pos", position[c*8 +: 8], r.pos);
                        if (c == 0) begin
                            check("sb_sat_valid", s_valid, 1);
                            check("sb_sat_dir", s_dir, r.dir);
                            check("sb_sat_pos", s_position, r.spos);
                        end
                    end
                end
            end
            if (s_error) err_s++;
            if (s_valid && !step_valid[0]) check("sat_orphan_step", step_valid[0], 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(3);
        check("rst_pos", position, 0);
        check("rst_valid", step_valid, 0);
        check("rst_err", error, 0);
        check("rst_leds", leds, 0);
        check("rst_spos", s_position, 0);
        reset = 1;
        wait_cyc(5);
        // single clockwise detent on channel 0
        turn(3'b001, 3'b000, 0);
        check("t1_pos", position[7:0], 8'd1);
        check("t1_leds", leds, 8'd1);
        // three counter-clockwise detents from zero
        clear = 3'b001;
        exp_pos[0] = 0;
        exp_s = 0;
        wait_cyc(1);
        clear = '0;
        repeat (3) turn(3'b000, 3'b001, 0);
        check("t2_pos", position[7:0], exp_pos[0]);
        check("t2_leds", leds, exp_pos[0]);
        check("t2_spos", s_position, exp_s);
`ifndef ROTARY_ACCEL_EN
        check("t2_pos_abs", position[7:0], 8'hFD);
`endif
        // A bounces on channel 1, then settles into a full detent
        for (int i = 0; i < 5; i++) begin
            rotary[2] = ~rotary[2];
            wait_cyc(2);
        end
        turn(3'b010, 3'b000, 0);
        check("t3_err", err_cnt[1], 0);
        check("t3_pos", position[15:8], exp_pos[1]);
        // illegal 00->11 jump on channel 2, then back out without a step
        rotary[5:4] = 2'b11;
        wait_cyc(10);
        check("t4_err", err_cnt[2], 1);
        check("t4_pos", position[23:16], exp_pos[2]);
        rotary[5:4] = 2'b10;
        wait_cyc(10);
        rotary[5:4] = 2'b00;
        wait_cyc(10);
        check("t4_err_after", err_cnt[2], 1);
        check("t4_pos_after", position[23:16], exp_pos[2]);
        // run channel 0 to the positive limit and one past it
        clear = 3'b001;
        exp_pos[0] = 0;
        exp_s = 0;
        wait_cyc(1);
        clear = '0;
        repeat (127) turn(3'b001, 3'b000, 0);
        check("t5_pos", position[7:0], exp_pos[0]);
        check("t5_spos", s_position, exp_s);
        turn(3'b001, 3'b000, 0);
        check("t5_wrap", position[7:0], exp_pos[0]);
        check("t5_sat", s_position, exp_s);
        check("t5_sleds", s_leds, exp_s);
`ifndef ROTARY_ACCEL_EN
        check("t5_wrap_abs", position[7:0], 8'h80);
        check("t5_sat_abs", s_position, 8'h7F);
`endif
        turn(3'b001, 3'b000, 1);
        check("t5_clear", position[7:0], 0);
        check("t5_sclear", s_position, 0);
        // simultaneous steps on channels 0 and 2
        clear = 3'b111;
        exp_pos = '{8'd0, 8'd0, 8'd0};
        exp_s = 0;
        wait_cyc(1);
        clear = '0;
        turn(3'b001, 3'b100, 0);
        check("t6_ch0", position[7:0], exp_pos[0]);
        check("t6_ch1", position[15:8], 0);
        check("t6_ch2", position[23:16], exp_pos[2]);
        sel = 3'd2;
        wait_cyc(2);
        check("t6_leds_sel2", leds, exp_pos[2]);
        sel = 3'd3;
        wait_cyc(2);
        check("t6_leds_oor", leds, 0);
        sel = 3'd0;
        wait_cyc(2);
        // asynchronous reset in the middle of a detent
        rotary = 6'b01_00_01;
        wait_cyc(10);
        rotary = 6'b11_00_11;
        wait_cyc(4);
        check("t6_sb_drained", q.size(), 0);
        #2 reset = 0;
        #1;
        check("t6_rst_pos", position, 0);
        check("t6_rst_valid", step_valid, 0);
        check("t6_rst_err", error, 0);
        check("t6_rst_leds", leds, 0);
        check("t6_rst_spos", s_position, 0);
        rotary = '0;
        wait_cyc(3);
        reset = 1;
        exp_pos = '{8'd0, 8'd0, 8'd0};
        exp_s = 0;
`ifdef ROTARY_ACCEL_EN
        have = '{0, 0, 0};
`endif
        wait_cyc(5);
`ifdef ROTARY_ACCEL_EN
        turn(3'b010, 3'b000, 0);
        wait_cyc(53);
        turn(3'b010, 3'b000, 0);
        check("accel_pos", position[15:8], 8'd5);
`endif
        check("sb_empty", q.size(), 0);
        check("err_ch0", err_cnt[0], 0);
        check("err_sat", err_s, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
